// File: rtl/stopwatch_cu_multi.sv
// stopwatch_cu_multi
// Control unit for CH independent stopwatch channels, driven by one-cycle
// debounced button pulses and UART command bytes qualified by pc_valid.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   btn_L     clear/lap button pulse
//   btn_R     run/stop button pulse
//   pc_data   UART RX byte
//   pc_valid  one-cycle strobe qualifying pc_data
//   sel       currently selected channel (commands apply only to it)
//   run_stop  per-channel run enable
//   hold      per-channel display freeze (lap)
//   clear     per-channel one-cycle clear pulse
//
// Optional feature macro: STOPWATCH_CU_LAP_EN
//   defined   : RUN + cmd_l enters LAP (run_stop=1, hold=1)
//   undefined : no LAP state, cmd_l ignored in RUN, hold tied to 0
//
// Per-channel FSM:
//   state    | meaning
//   ST_STOP  | stopped, cmd_r -> RUN, cmd_l -> CLEAR
//   ST_RUN   | counting, cmd_r -> STOP, cmd_l -> LAP (if enabled)
//   ST_LAP   | counting with display frozen, cmd_l -> RUN, cmd_r -> STOP
//   ST_CLEAR | one-cycle clear pulse, always returns to STOP
module stopwatch_cu_multi #(
  parameter int         CH       = 2,
  parameter int         SELW     = (CH > 1) ? $clog2(CH) : 1,
  parameter logic [7:0] CMD_RUN  = 8'h52,
  parameter logic [7:0] CMD_CLR  = 8'h4C,
  parameter logic [7:0] CMD_SEL0 = 8'h30
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            btn_L,
  input  logic            btn_R,
  input  logic [7:0]      pc_data,
  input  logic            pc_valid,
  output logic [SELW-1:0] sel,
  output logic [CH-1:0]   run_stop,
  output logic [CH-1:0]   hold,
  output logic [CH-1:0]   clear
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  localparam logic [7:0] CH8 = 8'(CH);

  state_t state_q [CH];
  state_t state_d [CH];

  logic       cmd_r;
  logic       cmd_l;
  logic       sel_hit;
  logic [7:0] sel_off;

  // Button and UART requests for the same command merge into one event;
  // run/stop takes priority when both commands land in the same cycle.
  always_comb begin
    cmd_r   = btn_R | (pc_valid & (pc_data == CMD_RUN));
    cmd_l   = (btn_L | (pc_valid & (pc_data == CMD_CLR))) & ~cmd_r;
    sel_off = pc_data - CMD_SEL0;
    sel_hit = pc_valid & (pc_data >= CMD_SEL0) & (sel_off < CH8);
  end

  generate
    if (CH > 1) begin : g_sel
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sel <= '0;
        end else if (sel_hit) begin
          sel <= sel_off[SELW-1:0];
        end
      end
    end else begin : g_sel_tie
      assign sel = '0;
    end
  endgenerate

  // Next-state: CLEAR and illegal recovery happen on every channel; command
  // transitions only on the channel selected before this edge.
  always_comb begin
    for (int k = 0; k < CH; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        ST_STOP: begin
          if ((SELW'(k) == sel) && cmd_r)      state_d[k] = ST_RUN;
          else if ((SELW'(k) == sel) && cmd_l) state_d[k] = ST_CLEAR;
        end
        ST_RUN: begin
          if ((SELW'(k) == sel) && cmd_r)      state_d[k] = ST_STOP;
`ifdef STOPWATCH_CU_LAP_EN
          else if ((SELW'(k) == sel) && cmd_l) state_d[k] = ST_LAP;
`endif
        end
`ifdef STOPWATCH_CU_LAP_EN
        ST_LAP: begin
          if ((SELW'(k) == sel) && cmd_r)      state_d[k] = ST_STOP;
          else if ((SELW'(k) == sel) && cmd_l) state_d[k] = ST_RUN;
        end
`endif
        ST_CLEAR: state_d[k] = ST_STOP;
        default:  state_d[k] = ST_STOP;
      endcase
    end
  end

  // Outputs are registered from the next state so they change in the same
  // cycle as the state register and never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CH; k++) state_q[k] <= ST_STOP;
      run_stop <= '0;
      clear    <= '0;
`ifdef STOPWATCH_CU_LAP_EN
      hold     <= '0;
`endif
    end else begin
      for (int k = 0; k < CH; k++) begin
        state_q[k]  <= state_d[k];
        run_stop[k] <= (state_d[k] == ST_RUN) || (state_d[k] == ST_LAP);
        clear[k]    <= (state_d[k] == ST_CLEAR);
`ifdef STOPWATCH_CU_LAP_EN
        hold[k]     <= (state_d[k] == ST_LAP);
`endif
      end
    end
  end

`ifndef STOPWATCH_CU_LAP_EN
  assign hold = '0;
`endif

endmodule

// File: tb/tb_stopwatch_cu_multi.sv
module tb_stopwatch_cu_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_L = 1'b0;
  logic       btn_R = 1'b0;
  logic [7:0] pc_data = 8'h00;
  logic       pc_valid = 1'b0;
  logic [0:0] sel;
  logic [1:0] run_stop;
  logic [1:0] hold;
  logic [1:0] clear;

  int vectors = 0;
  int errs = 0;

  stopwatch_cu_multi #(.CH(2)) dut (
    .clk(clk), .rst_n(rst_n), .btn_L(btn_L), .btn_R(btn_R),
    .pc_data(pc_data), .pc_valid(pc_valid),
    .sel(sel), .run_stop(run_stop), .hold(hold), .clear(clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic s, input logic [1:0] r,
                         input logic [1:0] h, input logic [1:0] c);
    chk({tag, ".sel"}, {7'd0, sel}, {7'd0, s});
    chk({tag, ".run"}, {6'd0, run_stop}, {6'd0, r});
    chk({tag, ".hold"}, {6'd0, hold}, {6'd0, h});
    chk({tag, ".clear"}, {6'd0, clear}, {6'd0, c});
  endtask

  // Drive inputs for one clock edge, then return 1 time unit after it.
  task automatic apply(input logic r, input logic l, input logic v, input logic [7:0] d);
    btn_R = r; btn_L = l; pc_valid = v; pc_data = d;
    @(posedge clk); #1;
    btn_R = 1'b0; btn_L = 1'b0; pc_valid = 1'b0; pc_data = 8'h00;
  endtask

  initial begin
    #2;
    chk_all("reset", 1'b0, 2'b00, 2'b00, 2'b00);
    @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("post_reset", 1'b0, 2'b00, 2'b00, 2'b00);

    apply(1, 0, 0, 8'h00);  chk_all("r0_run", 0, 2'b01, 2'b00, 2'b00);
    apply(1, 0, 0, 8'h00);  chk_all("r0_stop", 0, 2'b00, 2'b00, 2'b00);

    apply(0, 0, 1, 8'h31);  chk_all("sel1", 1, 2'b00, 2'b00, 2'b00);
    apply(0, 0, 1, 8'h52);  chk_all("uart_run1", 1, 2'b10, 2'b00, 2'b00);

    apply(0, 0, 1, 8'h30);  chk_all("sel0", 0, 2'b10, 2'b00, 2'b00);
    apply(0, 1, 0, 8'h00);  chk_all("clr0_pulse", 0, 2'b10, 2'b00, 2'b01);
    @(posedge clk); #1;     chk_all("clr0_end", 0, 2'b10, 2'b00, 2'b00);

    apply(1, 0, 0, 8'h00);  chk_all("r0_run2", 0, 2'b11, 2'b00, 2'b00);
`ifdef STOPWATCH_CU_LAP_EN
    apply(0, 1, 0, 8'h00);  chk_all("lap_on", 0, 2'b11, 2'b01, 2'b00);
    apply(0, 1, 0, 8'h00);  chk_all("lap_off", 0, 2'b11, 2'b00, 2'b00);
    apply(0, 1, 0, 8'h00);  chk_all("lap_on2", 0, 2'b11, 2'b01, 2'b00);
    apply(1, 0, 0, 8'h00);  chk_all("lap_stop", 0, 2'b10, 2'b00, 2'b00);
`else
    apply(0, 1, 0, 8'h00);  chk_all("l_in_run", 0, 2'b11, 2'b00, 2'b00);
    @(posedge clk); #1;     chk_all("l_in_run2", 0, 2'b11, 2'b00, 2'b00);
    apply(1, 0, 0, 8'h00);  chk_all("r0_stop2", 0, 2'b10, 2'b00, 2'b00);
`endif

    apply(1, 1, 0, 8'h00);  chk_all("rl_same", 0, 2'b11, 2'b00, 2'b00);
    @(posedge clk); #1;     chk_all("rl_same2", 0, 2'b11, 2'b00, 2'b00);
    apply(1, 0, 1, 8'h52);  chk_all("btn_uart_once", 0, 2'b10, 2'b00, 2'b00);
    apply(0, 0, 0, 8'h52);  chk_all("no_valid", 0, 2'b10, 2'b00, 2'b00);
    apply(0, 0, 0, 8'h4C);  chk_all("no_valid_l", 0, 2'b10, 2'b00, 2'b00);
    apply(0, 0, 1, 8'h39);  chk_all("sel_39", 0, 2'b10, 2'b00, 2'b00);
    apply(0, 0, 1, 8'h32);  chk_all("sel_32", 0, 2'b10, 2'b00, 2'b00);
    apply(0, 0, 1, 8'h41);  chk_all("other_byte", 0, 2'b10, 2'b00, 2'b00);

    apply(1, 0, 1, 8'h31);  chk_all("cmd_old_sel", 1, 2'b11, 2'b00, 2'b00);
    apply(1, 0, 0, 8'h00);  chk_all("r1_stop", 1, 2'b01, 2'b00, 2'b00);
    apply(0, 1, 0, 8'h00);  chk_all("clr1_pulse", 1, 2'b01, 2'b00, 2'b10);
    apply(1, 1, 0, 8'h00);  chk_all("cmd_in_clear", 1, 2'b01, 2'b00, 2'b00);

    apply(0, 1, 0, 8'h00);  chk_all("clr1_again", 1, 2'b01, 2'b00, 2'b10);
    rst_n = 1'b0; #1;
    chk_all("rst_mid_clear", 0, 2'b00, 2'b00, 2'b00);
    #2; rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1; chk_all("idle_after_rst", 0, 2'b00, 2'b00, 2'b00);

    apply(1, 0, 0, 8'h00);
    apply(0, 0, 1, 8'h31);
    apply(1, 0, 0, 8'h00);  chk_all("both_run", 1, 2'b11, 2'b00, 2'b00);
    #2; rst_n = 1'b0; #1;
    chk_all("rst_both_run", 0, 2'b00, 2'b00, 2'b00);
    #2; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1; chk_all("idle_after_rst2", 0, 2'b00, 2'b00, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
